eq_lut_builder: RTL and testbench
=================================

Name: eq_lut_builder

Overview:
- Consumer of the CDF table in scratch memory: reads 64 CDF words (4 × 32-bit bins per 128-bit word) and computes the histogram-equalization map lut[v] = (cdf[v] − cdf_min) × 255 / (total_pixels − cdf_min).
- Packs the 256 8-bit results 16 per word and writes them back to scratch memory for the pixel-remap stage.
- Runs once per frame, after the CDF stage finishes and cdf_min is stable.

Parameters:
- CDF_BASE, 16'd64, scratch-memory word address of CDF bins 0..3.
- LUT_BASE, 16'd128, word address of LUT bytes 0..15.
- NUM_WORDS, 64, number of CDF words read; LUT words written = NUM_WORDS/4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse, begin build
- cdf_min  in  32  first nonzero CDF value; held stable while busy
- total_pixels  in  32  pixel count (≤ 8294400); held stable while busy
- ReadAddress  out  16  scratch-memory read address
- scratchmem_input  in  128  read data, valid the cycle after ReadAddress is presented; bin 4k in [127:96] … bin 4k+3 in [31:0]
- WE  out  1  write enable, one-cycle pulse per LUT word
- WriteAddress  out  16  LUT word address
- WriteBus  out  128  LUT word; byte 16j in [127:120] … byte 16j+15 in [7:0]
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset: WE=0, done=0, busy=0, ReadAddress=CDF_BASE, WriteAddress=LUT_BASE, WriteBus=0, state=IDLE. Reset mid-build aborts immediately; no further writes occur.
- IDLE: start=1 → SETUP. start while busy is ignored.
- SETUP (1 cycle):
  - Latch denom = total_pixels − cdf_min.
  - degenerate = (denom==0).
  - ReadAddress=CDF_BASE, word counter=0.
- RD_ADDR (1 cycle): ReadAddress presented.
- RD_DATA (1 cycle): capture scratchmem_input; entry index e=0.
- DIV (9 cycles per entry):
  - Cycle 0, load numerator:
    - If cdf ≤ cdf_min: num=0.
    - Otherwise: num=(cdf−cdf_min)×255, computed at 32 bits; no overflow since cdf < 2^24.
  - Cycles 1–8: 8-step restoring division by denom. Quotient is 8 bits because num < 256 × denom.
  - If degenerate: result = bin index [7:0] (identity map); the 9-cycle timing is unchanged.
  - Each result is shifted into a 128-bit pack register, MSB byte first. e increments; after e=3:
    - If word counter[1:0]==3 → WRITE.
    - Else ReadAddress+=1 → RD_ADDR.
- WRITE (1 cycle):
  - WE=1, WriteBus=pack, WriteAddress=LUT_BASE + word counter/4.
  - If last word → DONE; else ReadAddress+=1 → RD_ADDR.
- DONE: done=1 for 1 cycle, busy=0 → IDLE.
- Latency: start accepted at cycle 0 → done at cycle 1 + 64×38 + 16 + 1 = 2450.
- WE pulses exactly 16 times per build, at strictly increasing addresses LUT_BASE..LUT_BASE+15.
- Addresses wrap modulo 2^16; no error signalled.

Optional Feature:
- EQ_ROUND_NEAREST_EN:
  - When defined, num += denom>>1 before division (round-to-nearest), and the result saturates at 255.
  - When undefined, truncating division as above.
  - Cycle count is identical either way.

Decomposition:
- Package cdf_pkg holds:
  - CDF_BASE, LUT_BASE, NUM_BINS=256, BINS_PER_WORD=4, LUT_BYTES_PER_WORD=16.
  - State encoding: IDLE, SETUP, RD_ADDR, RD_DATA, DIV, WRITE, DONE.
- One sub-module, eq_div8:
  - Start/valid handshake; 32-bit numerator and denominator in, 8-bit quotient out.
  - Exactly 8 iteration cycles.

Test Plan:
- Uniform histogram (each bin =1, total=256, cdf_min=1): lut[v]=v for all v; 16 writes at addresses 128..143; done at cycle 2450.
- Two bins (bin10=100, bin200=300, total=400, cdf_min=100): lut[0..199]=0, lut[200..255]=255; first WriteBus=0, last WriteBus=all-ones.
- Degenerate (bin0=8294400, total=8294400, cdf_min=8294400): identity map; word 0 = 128'h000102…0F.
- Rounding (bins 0,1,2 =1, total=3, cdf_min=1): lut[1]=127 without EQ_ROUND_NEAREST_EN, 128 with it; lut[0]=0, lut[2..255]=255.
- Reset asserted after the 5th WE, then a new start: no WE between reset and the restart; full 16-word rebuild follows from address 128.
- start re-pulsed at cycle 100 of a build: ignored; done fires once, at cycle 2450.

Source files
------------

// File: rtl/cdf_pkg.sv
// Shared constants and state encoding for the histogram-equalisation LUT builder.
//
// Contents:
//   CDF_BASE / LUT_BASE   scratch-memory word addresses of the CDF table and the LUT
//   NUM_BINS              number of intensity bins (8-bit pixels)
//   BINS_PER_WORD         32-bit CDF bins per 128-bit scratch word
//   LUT_BYTES_PER_WORD    8-bit LUT entries per 128-bit scratch word
//   NUM_WORDS             CDF words read per build
//   WORDS_PER_LUT         CDF words consumed per LUT word produced
//   state_t               builder FSM states
package cdf_pkg;

  localparam logic [15:0] CDF_BASE           = 16'd64;
  localparam logic [15:0] LUT_BASE           = 16'd128;
  localparam int          NUM_BINS           = 256;
  localparam int          BINS_PER_WORD      = 4;
  localparam int          LUT_BYTES_PER_WORD = 16;
  localparam int          NUM_WORDS          = NUM_BINS / BINS_PER_WORD;
  localparam int          WORDS_PER_LUT      = LUT_BYTES_PER_WORD / BINS_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD_ADDR,
    RD_DATA,
    DIV,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/eq_div8.sv
// 8-bit-quotient restoring divider.
//
// A start pulse loads the numerator and denominator; the divider then runs
// exactly 8 iteration cycles. valid is high during the 8th iteration cycle and
// quotient carries the completed result combinationally in that same cycle, so
// a caller can retire it on the clock edge that ends the 8th iteration.
// The caller guarantees num < 256*den, so 8 quotient bits suffice.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        load operands and begin (ignored unless idle)
//   num, den     32-bit numerator / denominator
//   valid        high in the final iteration cycle
//   quotient     8-bit result, meaningful while valid is high
module eq_div8 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic        valid,
  output logic [7:0]  quotient
);

  logic [31:0] rem_q, rem_d;
  logic [39:0] dsh_q, dsh_d;   // denominator aligned to the current quotient bit
  logic [7:0]  q_q, q_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ge;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      dsh_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      dsh_q <= dsh_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  // When ge is true dsh_q <= rem_q, so the subtraction fits in 32 bits.
  assign ge = ({8'd0, rem_q} >= dsh_q);

  always_comb begin
    rem_d = rem_q;
    dsh_d = dsh_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    if (cnt_q == 4'd0) begin
      if (start) begin
        rem_d = num;
        dsh_d = {1'b0, den, 7'd0};
        q_d   = '0;
        cnt_d = 4'd8;
      end
    end else begin
      if (ge) begin
        rem_d = rem_q - dsh_q[31:0];
      end
      dsh_d = dsh_q >> 1;
      q_d   = {q_q[6:0], ge};
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign valid    = (cnt_q == 4'd1);
  assign quotient = {q_q[6:0], ge};

endmodule

// File: rtl/eq_lut_builder.sv
// Histogram-equalisation LUT builder.
//
// Reads the 256-bin CDF (4 bins per 128-bit scratch word), computes
//   lut[v] = (cdf[v] - cdf_min) * 255 / (total_pixels - cdf_min)
// and writes the 256 bytes back 16 per word, MSB byte first.
// If total_pixels == cdf_min the map degenerates to the identity.
//
// Optional build macro EQ_ROUND_NEAREST_EN: adds denom/2 to each numerator
// (round-to-nearest) and saturates the result at 255. Timing is unchanged.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle pulse, begin a build (ignored while busy)
//   cdf_min             first nonzero CDF value, stable while busy
//   total_pixels        pixel count, stable while busy
//   ReadAddress         scratch read address
//   scratchmem_input    read data, valid the cycle after ReadAddress
//   WE                  one-cycle write strobe per LUT word
//   WriteAddress        LUT word address
//   WriteBus            LUT word data
//   busy                build in progress
//   done                one-cycle pulse after the last write
module eq_lut_builder
  import cdf_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  cdf_min,
  input  logic [31:0]  total_pixels,
  output logic [15:0]  ReadAddress,
  input  logic [127:0] scratchmem_input,
  output logic         WE,
  output logic [15:0]  WriteAddress,
  output logic [127:0] WriteBus,
  output logic         busy,
  output logic         done
);

  state_t       state_q, state_d;
  logic [15:0]  rd_addr_q, rd_addr_d;
  logic [5:0]   wc_q, wc_d;          // CDF word counter
  logic [1:0]   e_q, e_d;            // bin within current CDF word
  logic [127:0] data_q, data_d;
  logic [127:0] pack_q, pack_d;
  logic [31:0]  denom_q, denom_d;
  logic         degen_q, degen_d;
  logic         div_run_q, div_run_d; // divider launched for the current entry
  logic         sat_q, sat_d;

  logic [31:0]  cdf_sel, diff, num_base, num_div;
  logic         sat_now;
  logic         div_start, div_valid;
  logic [7:0]   div_quot, result_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= CDF_BASE;
      wc_q      <= '0;
      e_q       <= '0;
      data_q    <= '0;
      pack_q    <= '0;
      denom_q   <= '0;
      degen_q   <= 1'b0;
      div_run_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wc_q      <= wc_d;
      e_q       <= e_d;
      data_q    <= data_d;
      pack_q    <= pack_d;
      denom_q   <= denom_d;
      degen_q   <= degen_d;
      div_run_q <= div_run_d;
      sat_q     <= sat_d;
    end
  end

  // Bin 4k sits in the top lane of the captured word.
  always_comb begin
    cdf_sel = data_q[127:96];
    case (e_q)
      2'd0:    cdf_sel = data_q[127:96];
      2'd1:    cdf_sel = data_q[95:64];
      2'd2:    cdf_sel = data_q[63:32];
      default: cdf_sel = data_q[31:0];
    endcase
  end

  // cdf < 2^24, so the x255 product stays within 32 bits.
  assign diff     = cdf_sel - cdf_min;
  assign num_base = (cdf_sel > cdf_min) ? diff * 32'd255 : 32'd0;

`ifdef EQ_ROUND_NEAREST_EN
  assign num_div = num_base + (denom_q >> 1);
  // A quotient of 256 or more cannot be produced in 8 steps; clamp instead.
  assign sat_now = ({8'd0, num_div} >= {denom_q, 8'd0});
`else
  assign num_div = num_base;
  assign sat_now = 1'b0;
`endif

  eq_div8 u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .num      (num_div),
    .den      (denom_q),
    .valid    (div_valid),
    .quotient (div_quot)
  );

  // Degenerate map is the identity: bin index = {word, entry}.
  assign result_byte = degen_q ? {wc_q, e_q} : (sat_q ? 8'hFF : div_quot);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wc_d      = wc_q;
    e_d       = e_q;
    data_d    = data_q;
    pack_d    = pack_q;
    denom_d   = denom_q;
    degen_d   = degen_q;
    div_run_d = div_run_q;
    sat_d     = sat_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETUP;
      end
      SETUP: begin
        denom_d   = total_pixels - cdf_min;
        degen_d   = (total_pixels == cdf_min);
        rd_addr_d = CDF_BASE;
        wc_d      = '0;
        e_d       = '0;
        div_run_d = 1'b0;
        state_d   = RD_ADDR;
      end
      RD_ADDR: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        data_d    = scratchmem_input;
        e_d       = '0;
        div_run_d = 1'b0;
        state_d   = DIV;
      end
      DIV: begin
        if (!div_run_q) begin
          // Entry cycle 0: launch the divider with this bin's numerator.
          div_start = 1'b1;
          div_run_d = 1'b1;
          sat_d     = sat_now;
        end else if (div_valid) begin
          pack_d    = {pack_q[119:0], result_byte};
          div_run_d = 1'b0;
          e_d       = e_q + 2'd1;
          if (e_q == 2'd3) begin
            if (wc_q[1:0] == 2'(WORDS_PER_LUT - 1)) begin
              state_d = WRITE;
            end else begin
              rd_addr_d = rd_addr_q + 16'd1;
              wc_d      = wc_q + 6'd1;
              state_d   = RD_ADDR;
            end
          end
        end
      end
      WRITE: begin
        if (wc_q == 6'(NUM_WORDS - 1)) begin
          state_d = DONE;
        end else begin
          rd_addr_d = rd_addr_q + 16'd1;
          wc_d      = wc_q + 6'd1;
          state_d   = RD_ADDR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ReadAddress  = rd_addr_q;
  assign WE           = (state_q == WRITE);
  assign WriteAddress = LUT_BASE + {10'd0, wc_q[5:2]};
  assign WriteBus     = pack_q;
  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_eq_lut_builder.sv
// Directed testbench for eq_lut_builder with a synchronous-read CDF memory model.
module tb_eq_lut_builder;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  cdf_min;
  logic [31:0]  total_pixels;
  logic [15:0]  ReadAddress;
  logic [127:0] scratchmem_input;
  logic         WE;
  logic [15:0]  WriteAddress;
  logic [127:0] WriteBus;
  logic         busy;
  logic         done;

  logic [127:0] cdf_mem [0:63];
  logic [15:0]  wr_addr [$];
  logic [127:0] wr_data [$];
  int           hist [256];
  int           checks = 0;
  int           passes = 0;

  eq_lut_builder dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cdf_min          (cdf_min),
    .total_pixels     (total_pixels),
    .ReadAddress      (ReadAddress),
    .scratchmem_input (scratchmem_input),
    .WE               (WE),
    .WriteAddress     (WriteAddress),
    .WriteBus         (WriteBus),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Read data appears the cycle after the address is presented.
  always @(posedge clk) begin
    if (ReadAddress >= 16'd64 && ReadAddress < 16'd128)
      scratchmem_input <= cdf_mem[ReadAddress[5:0]];
    else
      scratchmem_input <= '0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_hist(input logic [31:0] tot, input logic [31:0] mn);
    logic [31:0] acc;
    acc = 0;
    for (int v = 0; v < 256; v++) begin
      acc = acc + 32'(hist[v]);
      cdf_mem[v/4][127-32*(v%4) -: 32] = acc;
    end
    total_pixels = tot;
    cdf_min      = mn;
  endtask

  task automatic clear_hist();
    for (int v = 0; v < 256; v++) hist[v] = 0;
  endtask

  function automatic logic [127:0] ident_word(input int j);
    logic [127:0] w;
    w = '0;
    for (int b = 0; b < 16; b++) w[127-8*b -: 8] = 8'(16*j + b);
    return w;
  endfunction

  // Pulses start, then watches one cycle per negedge (k = cycle index after acceptance).
  // repulse_at>0 re-pulses start at that cycle; abort_after>0 raises reset after that many writes.
  task automatic run_build(input int repulse_at, input int abort_after,
                           output int done_k, output int done_cnt);
    wr_addr.delete();
    wr_data.delete();
    done_k   = -1;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start = (k == repulse_at);
      if (k == 1) chk("busy_after_start", 128'(busy), 128'(1));
      if (WE) begin
        wr_addr.push_back(WriteAddress);
        wr_data.push_back(WriteBus);
        $display("cycle %0d WE addr=%0d data=%h", k, WriteAddress, WriteBus);
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (abort_after > 0 && wr_addr.size() == abort_after) begin
        reset = 1'b1;
        break;
      end
      if (done_k >= 0 && k >= done_k + 20) break;
    end
    start = 1'b0;
  endtask

  task automatic check_uniform(input string tag, input int dk, input int dc);
    chk({tag, "_done_cycle"}, 128'(dk), 128'(2450));
    chk({tag, "_done_count"}, 128'(dc), 128'(1));
    chk({tag, "_num_writes"}, 128'(wr_addr.size()), 128'(16));
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 128'(wr_addr[i]), 128'(128 + i));
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], ident_word(i));
    end
  endtask

  initial begin
    int dk, dc, we_seen;
    logic [127:0] exp_w;
    reset = 1'b1;
    start = 1'b0;
    clear_hist();
    load_hist(32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_WE", 128'(WE), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ReadAddress", 128'(ReadAddress), 128'(64));
    chk("rst_WriteAddress", 128'(WriteAddress), 128'(128));
    chk("rst_WriteBus", WriteBus, 128'(0));

    // Uniform histogram: identity map.
    for (int v = 0; v < 256; v++) hist[v] = 1;
    load_hist(32'd256, 32'd1);
    run_build(0, 0, dk, dc);
    check_uniform("uniform", dk, dc);
    chk("uniform_busy_idle", 128'(busy), 128'(0));

    // Two occupied bins: step from 0 to 255 at bin 200.
    clear_hist();
    hist[10] = 100;
    hist[200] = 300;
    load_hist(32'd400, 32'd100);
    run_build(0, 0, dk, dc);
    chk("twobin_done_cycle", 128'(dk), 128'(2450));
    chk("twobin_num_writes", 128'(wr_addr.size()), 128'(16));
    if (wr_addr.size() == 16) begin
      chk("twobin_word0", wr_data[0], 128'(0));
      chk("twobin_word11", wr_data[11], 128'(0));
      chk("twobin_word12", wr_data[12], {64'd0, {64{1'b1}}});
      chk("twobin_word15", wr_data[15], {128{1'b1}});
      chk("twobin_addr15", 128'(wr_addr[15]), 128'(143));
    end

    // Degenerate: all pixels in bin 0, identity map.
    clear_hist();
    hist[0] = 8294400;
    load_hist(32'd8294400, 32'd8294400);
    run_build(0, 0, dk, dc);
    chk("degen_done_cycle", 128'(dk), 128'(2450));
    chk("degen_num_writes", 128'(wr_addr.size()), 128'(16));
    if (wr_addr.size() == 16) begin
      chk("degen_word0", wr_data[0], 128'h000102030405060708090A0B0C0D0E0F);
      chk("degen_word15", wr_data[15], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    end

    // Rounding: denom 2, lut[1] = 255/2.
    clear_hist();
    hist[0] = 1;
    hist[1] = 1;
    hist[2] = 1;
    load_hist(32'd3, 32'd1);
    run_build(0, 0, dk, dc);
    chk("round_num_writes", 128'(wr_addr.size()), 128'(16));
`ifdef EQ_ROUND_NEAREST_EN
    exp_w = {8'h00, 8'h80, {112{1'b1}}};
`else
    exp_w = {8'h00, 8'h7F, {112{1'b1}}};
`endif
    if (wr_addr.size() == 16) begin
      chk("round_word0", wr_data[0], exp_w);
      chk("round_word1", wr_data[1], {128{1'b1}});
    end

    // Reset after the 5th write, then a clean rebuild.
    for (int v = 0; v < 256; v++) hist[v] = 1;
    load_hist(32'd256, 32'd1);
    run_build(0, 5, dk, dc);
    chk("abort_writes_before_reset", 128'(wr_addr.size()), 128'(5));
    we_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      if (WE) we_seen++;
    end
    chk("abort_we_after_reset", 128'(we_seen), 128'(0));
    chk("abort_busy_after_reset", 128'(busy), 128'(0));
    run_build(0, 0, dk, dc);
    check_uniform("rebuild", dk, dc);

    // start re-pulsed mid-build is ignored.
    run_build(100, 0, dk, dc);
    check_uniform("repulse", dk, dc);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
